eeprom_access_arbiter: RTL and testbench

//  Shares a single I2C EEPROM byte-access engine between two requesters.

---
 rtl/eeprom_access_arbiter.sv | 166 ++++++++++++++++
 tb/tb_eeprom_access_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_access_arbiter.sv
// Round-robin arbiter sharing one I2C EEPROM byte-access engine between two requesters.
// It latches the winning command, drives the engine strobes, enforces the write-cycle gap and returns one response per command.
module eeprom_access_arbiter #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int WR_GAP_CYC  = 5000,
    parameter int CNT_W       = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req0_we,
    input  logic [10:0] req0_addr,
    input  logic [7:0]  req0_wdata,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic        req1_we,
    input  logic [10:0] req1_addr,
    input  logic [7:0]  req1_wdata,
    output logic        req1_ready,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        eep_wr,
    output logic        eep_rd,
    output logic [10:0] eep_addr,
    output logic [7:0]  eep_data,
    input  logic        eep_ack,
    input  logic [7:0]  eep_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(WR_GAP_CYC - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             prio1, prio1_nxt;
    logic             cmd_we, cmd_we_nxt;
    logic             cmd_id, cmd_id_nxt;
    logic [10:0]      cmd_addr, cmd_addr_nxt;
    logic [7:0]       cmd_wdata, cmd_wdata_nxt;
    logic             eep_wr_nxt, eep_rd_nxt;
    logic             rsp_valid_nxt, rsp_id_nxt, rsp_err_nxt;
    logic [7:0]       rsp_rdata_nxt;

    logic grant_ok;
    logic grant_any;
    logic pick1;

    // Grants wait out the response cycle so IDLE always lasts at least one cycle before the next grant.
    assign grant_ok   = (state == IDLE) && !rsp_valid;
    assign pick1      = req1_valid && (!req0_valid || prio1);
    assign grant_any  = grant_ok && (req0_valid || req1_valid);
    assign req0_ready = grant_any && !pick1;
    assign req1_ready = grant_any && pick1;

    assign eep_addr = cmd_addr;
    assign eep_data = cmd_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            prio1     <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_id    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            eep_wr    <= 1'b0;
            eep_rd    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            prio1     <= prio1_nxt;
            cmd_we    <= cmd_we_nxt;
            cmd_id    <= cmd_id_nxt;
            cmd_addr  <= cmd_addr_nxt;
            cmd_wdata <= cmd_wdata_nxt;
            eep_wr    <= eep_wr_nxt;
            eep_rd    <= eep_rd_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_id    <= rsp_id_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        prio1_nxt     = prio1;
        cmd_we_nxt    = cmd_we;
        cmd_id_nxt    = cmd_id;
        cmd_addr_nxt  = cmd_addr;
        cmd_wdata_nxt = cmd_wdata;
        eep_wr_nxt    = eep_wr;
        eep_rd_nxt    = eep_rd;
        rsp_valid_nxt = 1'b0;
        rsp_id_nxt    = rsp_id;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;

        case (state)
            IDLE: begin
                if (grant_any) begin
                    cmd_id_nxt    = pick1;
                    cmd_we_nxt    = pick1 ? req1_we : req0_we;
                    cmd_addr_nxt  = pick1 ? req1_addr : req0_addr;
                    cmd_wdata_nxt = pick1 ? req1_wdata : req0_wdata;
                    prio1_nxt     = !pick1;
                    eep_wr_nxt    = pick1 ? req1_we : req0_we;
                    eep_rd_nxt    = pick1 ? !req1_we : !req0_we;
                    cnt_nxt       = '0;
                    state_nxt     = BUSY;
                end
            end

            BUSY: begin
                cnt_nxt = cnt + CNT_W'(1);
                // An ack arriving on the timeout cycle still counts as a normal completion.
                if (eep_ack) begin
                    eep_wr_nxt    = 1'b0;
                    eep_rd_nxt    = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_id_nxt    = cmd_id;
                    rsp_err_nxt   = 1'b0;
                    rsp_rdata_nxt = cmd_we ? 8'h00 : eep_rdata;
                    cnt_nxt       = '0;
                    state_nxt     = cmd_we ? GAP : IDLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    eep_wr_nxt    = 1'b0;
                    eep_rd_nxt    = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_id_nxt    = cmd_id;
                    rsp_err_nxt   = 1'b1;
                    rsp_rdata_nxt = 8'h00;
                    cnt_nxt       = '0;
                    state_nxt     = GAP;
                end
            end

            GAP: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == GAP_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_eeprom_access_arbiter.sv
// Directed self-checking bench for eeprom_access_arbiter.
// Small TIMEOUT/GAP values keep the run short; the engine is modelled by the stimulus sequence itself.
module tb_eeprom_access_arbiter;

    localparam int TIMEOUT_CYC = 64;
    localparam int WR_GAP_CYC  = 50;
    localparam int CNT_W       = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid, req0_we, req0_ready;
    logic [10:0] req0_addr;
    logic [7:0]  req0_wdata;
    logic        req1_valid, req1_we, req1_ready;
    logic [10:0] req1_addr;
    logic [7:0]  req1_wdata;
    logic        rsp_valid, rsp_id, rsp_err;
    logic [7:0]  rsp_rdata;
    logic        eep_wr, eep_rd, eep_ack;
    logic [10:0] eep_addr;
    logic [7:0]  eep_data, eep_rdata;

    int checks   = 0;
    int failures = 0;
    int waited, seen, gid, high;

    eeprom_access_arbiter #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .WR_GAP_CYC (WR_GAP_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .eep_wr     (eep_wr),
        .eep_rd     (eep_rd),
        .eep_addr   (eep_addr),
        .eep_data   (eep_data),
        .eep_ack    (eep_ack),
        .eep_rdata  (eep_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic we0, input logic [10:0] a0, input logic [7:0] d0,
                                 input logic v1, input logic we1, input logic [10:0] a1, input logic [7:0] d1);
        req0_valid = v0;
        req0_we    = we0;
        req0_addr  = a0;
        req0_wdata = d0;
        req1_valid = v1;
        req1_we    = we1;
        req1_addr  = a1;
        req1_wdata = d1;
    endtask

    // Polls for a grant from the current negedge; optionally injects a stray ack, counts rsp pulses after cycle 0.
    task automatic waitGrant(input int stray_at, output int n_wait, output int n_rsp, output int g);
        n_wait = 0;
        n_rsp  = 0;
        g      = -1;
        for (int i = 0; i < 4 * (WR_GAP_CYC + TIMEOUT_CYC); i++) begin
            if (i > 0 && rsp_valid === 1'b1) n_rsp++;
            #1;
            if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
                g = (req1_ready === 1'b1) ? 1 : 0;
                break;
            end
            eep_ack   = (i == stray_at);
            eep_rdata = 8'h77;
            @(negedge clk);
            n_wait++;
        end
        eep_ack   = 1'b0;
        eep_rdata = 8'h00;
        checkOutput("grant_seen", 32'(g >= 0), 32'd1);
    endtask

    // Called at the first BUSY negedge; acks in the n-th strobe cycle and returns at the response negedge.
    task automatic serveAck(input int n, input logic [7:0] rd, output int n_high);
        n_high = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            if (eep_rd === 1'b1 || eep_wr === 1'b1) n_high++;
            if (i == n - 1) begin
                eep_ack   = 1'b1;
                eep_rdata = rd;
            end
        end
        @(negedge clk);
        eep_ack   = 1'b0;
        eep_rdata = 8'h00;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before end of sequence");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        applyStimulus(0, 0, 11'h0, 8'h0, 0, 0, 11'h0, 8'h0);
        eep_ack   = 1'b0;
        eep_rdata = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("rst_eep_wr", 32'(eep_wr), 32'd0);
        checkOutput("rst_eep_rd", 32'(eep_rd), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_eep_addr", 32'(eep_addr), 32'd0);
        checkOutput("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] single read");
        applyStimulus(1, 0, 11'h123, 8'h00, 0, 0, 11'h0, 8'h0);
        waitGrant(-1, waited, seen, gid);
        checkOutput("t1_grant_id", 32'(gid), 32'd0);
        checkOutput("t1_grant_wait", 32'(waited), 32'd0);
        @(negedge clk);
        applyStimulus(0, 0, 11'h0, 8'h0, 0, 0, 11'h0, 8'h0);
        checkOutput("t1_eep_rd", 32'(eep_rd), 32'd1);
        checkOutput("t1_eep_wr", 32'(eep_wr), 32'd0);
        checkOutput("t1_eep_addr", 32'(eep_addr), 32'h123);
        serveAck(40, 8'hA5, high);
        checkOutput("t1_rd_high_cycles", 32'(high), 32'd40);
        checkOutput("t1_rd_dropped", 32'(eep_rd), 32'd0);
        checkOutput("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("t1_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("t1_rsp_rdata", 32'(rsp_rdata), 32'hA5);
        checkOutput("t1_rsp_err", 32'(rsp_err), 32'd0);
        applyStimulus(0, 0, 11'h0, 8'h0, 1, 0, 11'h321, 8'h00);
        waitGrant(-1, waited, seen, gid);
        checkOutput("t1_next_id", 32'(gid), 32'd1);
        checkOutput("t1_no_gap", 32'(waited <= 1), 32'd1);
        @(negedge clk);
        applyStimulus(0, 0, 11'h0, 8'h0, 0, 0, 11'h0, 8'h0);
        serveAck(1, 8'h5C, high);
        checkOutput("t1b_rsp_id", 32'(rsp_id), 32'd1);
        checkOutput("t1b_rsp_rdata", 32'(rsp_rdata), 32'h5C);

        $display("[TB] write gap and stray ack in GAP");
        applyStimulus(0, 0, 11'h0, 8'h0, 1, 1, 11'h7FF, 8'h3C);
        waitGrant(-1, waited, seen, gid);
        checkOutput("t2_grant_id", 32'(gid), 32'd1);
        @(negedge clk);
        applyStimulus(0, 0, 11'h0, 8'h0, 0, 0, 11'h0, 8'h0);
        checkOutput("t2_eep_wr", 32'(eep_wr), 32'd1);
        checkOutput("t2_eep_rd", 32'(eep_rd), 32'd0);
        checkOutput("t2_eep_addr", 32'(eep_addr), 32'h7FF);
        checkOutput("t2_eep_data", 32'(eep_data), 32'h3C);
        serveAck(5, 8'hEE, high);
        checkOutput("t2_wr_high_cycles", 32'(high), 32'd5);
        checkOutput("t2_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("t2_rsp_id", 32'(rsp_id), 32'd1);
        checkOutput("t2_rsp_rdata", 32'(rsp_rdata), 32'h00);
        checkOutput("t2_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("t2_wr_dropped", 32'(eep_wr), 32'd0);
        applyStimulus(1, 0, 11'h0A0, 8'h00, 0, 0, 11'h0, 8'h0);
        waitGrant(10, waited, seen, gid);
        checkOutput("t2_gap_wait", 32'(waited), 32'(WR_GAP_CYC));
        checkOutput("t2_gap_stray_rsp", 32'(seen), 32'd0);
        checkOutput("t2_after_gap_id", 32'(gid), 32'd0);
        @(negedge clk);
        applyStimulus(0, 0, 11'h0, 8'h0, 0, 0, 11'h0, 8'h0);
        serveAck(3, 8'h5A, high);
        checkOutput("t2b_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("t2b_rsp_rdata", 32'(rsp_rdata), 32'h5A);

        $display("[TB] stray ack in IDLE");
        @(negedge clk);
        eep_ack   = 1'b1;
        eep_rdata = 8'h99;
        @(negedge clk);
        eep_ack   = 1'b0;
        eep_rdata = 8'h00;
        checkOutput("t5_idle_rsp", 32'(rsp_valid), 32'd0);
        checkOutput("t5_idle_rd", 32'(eep_rd), 32'd0);
        checkOutput("t5_idle_wr", 32'(eep_wr), 32'd0);
        @(negedge clk);
        checkOutput("t5_idle_rsp_late", 32'(rsp_valid), 32'd0);

        $display("[TB] contention from reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        applyStimulus(1, 0, 11'h010, 8'h00, 1, 0, 11'h020, 8'h00);
        for (int k = 0; k < 4; k++) begin
            waitGrant(-1, waited, seen, gid);
            checkOutput($sformatf("t3_grant%0d", k), 32'(gid), 32'(k % 2));
            checkOutput($sformatf("t3_onehot%0d", k), 32'(req0_ready & req1_ready), 32'd0);
            @(negedge clk);
            if (k == 3) applyStimulus(0, 0, 11'h0, 8'h0, 0, 0, 11'h0, 8'h0);
            checkOutput($sformatf("t3_addr%0d", k), 32'(eep_addr), (k % 2 == 1) ? 32'h020 : 32'h010);
            serveAck(2, 8'(8'h10 + k), high);
            checkOutput($sformatf("t3_rsp_id%0d", k), 32'(rsp_id), 32'(k % 2));
            checkOutput($sformatf("t3_rsp_rdata%0d", k), 32'(rsp_rdata), 32'(8'h10 + k));
        end

        $display("[TB] timeout");
        @(negedge clk);
        applyStimulus(1, 1, 11'h055, 8'h99, 0, 0, 11'h0, 8'h0);
        waitGrant(-1, waited, seen, gid);
        checkOutput("t4_grant_id", 32'(gid), 32'd0);
        @(negedge clk);
        applyStimulus(0, 0, 11'h0, 8'h0, 0, 0, 11'h0, 8'h0);
        high = 0;
        while (eep_wr === 1'b1 && high < 4 * TIMEOUT_CYC) begin
            high++;
            @(negedge clk);
        end
        checkOutput("t4_strobe_cycles", 32'(high), 32'(TIMEOUT_CYC));
        checkOutput("t4_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("t4_rsp_err", 32'(rsp_err), 32'd1);
        checkOutput("t4_rsp_rdata", 32'(rsp_rdata), 32'h00);
        checkOutput("t4_rsp_id", 32'(rsp_id), 32'd0);
        applyStimulus(0, 0, 11'h0, 8'h0, 1, 0, 11'h111, 8'h00);
        waitGrant(10, waited, seen, gid);
        checkOutput("t4_gap_wait", 32'(waited), 32'(WR_GAP_CYC));
        checkOutput("t4_gap_stray_rsp", 32'(seen), 32'd0);
        checkOutput("t4_after_gap_id", 32'(gid), 32'd1);
        @(negedge clk);
        applyStimulus(0, 0, 11'h0, 8'h0, 0, 0, 11'h0, 8'h0);
        serveAck(1, 8'hC3, high);
        checkOutput("t4b_rsp_id", 32'(rsp_id), 32'd1);
        checkOutput("t4b_rsp_rdata", 32'(rsp_rdata), 32'hC3);
        checkOutput("t4b_rsp_err", 32'(rsp_err), 32'd0);

        $display("[TB] reset mid-BUSY");
        @(negedge clk);
        applyStimulus(1, 1, 11'h0AA, 8'h11, 0, 0, 11'h0, 8'h0);
        waitGrant(-1, waited, seen, gid);
        checkOutput("t6_grant_id", 32'(gid), 32'd0);
        @(negedge clk);
        applyStimulus(0, 0, 11'h0, 8'h0, 0, 0, 11'h0, 8'h0);
        checkOutput("t6_eep_wr_busy", 32'(eep_wr), 32'd1);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t6_async_wr", 32'(eep_wr), 32'd0);
        checkOutput("t6_async_addr", 32'(eep_addr), 32'd0);
        checkOutput("t6_async_data", 32'(eep_data), 32'd0);
        checkOutput("t6_async_rsp", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        checkOutput("t6_post_rsp", 32'(rsp_valid), 32'd0);
        applyStimulus(1, 0, 11'h001, 8'h00, 1, 0, 11'h002, 8'h00);
        waitGrant(-1, waited, seen, gid);
        checkOutput("t6_first_winner", 32'(gid), 32'd0);
        @(negedge clk);
        applyStimulus(0, 0, 11'h0, 8'h0, 0, 0, 11'h0, 8'h0);
        checkOutput("t6_eep_rd", 32'(eep_rd), 32'd1);
        checkOutput("t6_eep_addr", 32'(eep_addr), 32'h001);
        serveAck(1, 8'h42, high);
        checkOutput("t6_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("t6_rsp_rdata", 32'(rsp_rdata), 32'h42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
